// File: rtl/hanoi_core.sv
`default_nettype none
// ============================================================================
// hanoi_core : Hanoi esolang interpreter (pegs, hand, bag, run-time bracket seek)
// Rev 1.0
// ============================================================================
module hanoi_core #(
  parameter int N_DISKS    = 3,
  parameter int N_PEGS     = 3,
  parameter int PROG_DEPTH = 16,
  parameter int STEP_W     = 16,
  parameter int MAX_STEPS  = 1000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          prog_we,
  input  logic [$clog2(PROG_DEPTH)-1:0] prog_addr,
  input  logic [2:0]                    prog_data,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          solved,
  output logic [1:0]                    fault,
  output logic [STEP_W-1:0]             step_count,
  output logic [N_PEGS*N_DISKS-1:0]     peg_state,
  output logic [N_DISKS-1:0]            held,
  output logic [N_DISKS-1:0]            bag
);

  localparam int AW    = $clog2(PROG_DEPTH);
  localparam int PW    = $clog2(PROG_DEPTH + 1);
  localparam int DW    = PW + 1;
  localparam int PTR_W = $clog2(N_PEGS);
  localparam int PSW   = N_PEGS * N_DISKS;

  localparam logic [2:0] TOK_LEFT       = 3'd0;
  localparam logic [2:0] TOK_RIGHT      = 3'd1;
  localparam logic [2:0] TOK_INTERACT   = 3'd2;
  localparam logic [2:0] TOK_LOOP_BEGIN = 3'd3;
  localparam logic [2:0] TOK_LOOP_END   = 3'd4;
  localparam logic [2:0] TOK_SWAP       = 3'd5;
  localparam logic [2:0] TOK_HALT       = 3'd6;

  localparam logic [1:0] FLT_NONE      = 2'd0;
  localparam logic [1:0] FLT_UNMATCHED = 2'd1;
  localparam logic [1:0] FLT_TIMEOUT   = 2'd2;
  localparam logic [1:0] FLT_ILLEGAL   = 2'd3;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_EXEC      = 3'd1;
  localparam logic [2:0] ST_SEEK_FWD  = 3'd2;
  localparam logic [2:0] ST_SEEK_BACK = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;

  localparam logic [PW-1:0]     DEPTH_P   = PW'(PROG_DEPTH);
  localparam logic [PW-1:0]     PC_ONE    = PW'(1);
  localparam logic [DW-1:0]     DEPTH_ONE = DW'(1);
  localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
  localparam logic [STEP_W-1:0] MAX_P     = STEP_W'(MAX_STEPS);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(N_PEGS - 1);
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
  localparam logic [PSW-1:0]    PEGS_INIT = {{((N_PEGS-1)*N_DISKS){1'b0}}, {N_DISKS{1'b1}}};

  logic [2:0]         mem_q [PROG_DEPTH];

  logic [2:0]         state_q,  state_d;
  logic [PW-1:0]      pc_q,     pc_d;
  logic [PTR_W-1:0]   ptr_q,    ptr_d;
  logic [DW-1:0]      depth_q,  depth_d;
  logic [PSW-1:0]     pegs_q,   pegs_d;
  logic [N_DISKS-1:0] held_q,   held_d;
  logic [N_DISKS-1:0] bag_q,    bag_d;
  logic [STEP_W-1:0]  steps_q,  steps_d;
  logic               solved_q, solved_d;
  logic [1:0]         fault_q,  fault_d;

  logic               pc_in_range;
  logic [2:0]         tok;
  logic [N_DISKS-1:0] cur_peg;
  logic [N_DISKS-1:0] top_bit;
  logic               exec_counted;
  logic               any_full;
  logic [DW-1:0]      depth_n;

  // Program memory deliberately has no reset so a loaded program survives rst_n.
  always_ff @(posedge clk) begin
    if (prog_we && !busy) begin
      mem_q[prog_addr] <= prog_data;
    end
  end

  always_comb begin
    pc_in_range = (pc_q < DEPTH_P);
    tok         = pc_in_range ? mem_q[pc_q[AW-1:0]] : TOK_HALT;
    cur_peg     = pegs_q[int'(ptr_q)*N_DISKS +: N_DISKS];
    top_bit     = '0;
    for (int i = 0; i < N_DISKS; i++) begin
      if (cur_peg[i]) begin
        top_bit    = '0;
        top_bit[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      ptr_q    <= '0;
      depth_q  <= '0;
      pegs_q   <= PEGS_INIT;
      held_q   <= '0;
      bag_q    <= '0;
      steps_q  <= '0;
      solved_q <= 1'b0;
      fault_q  <= FLT_NONE;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ptr_q    <= ptr_d;
      depth_q  <= depth_d;
      pegs_q   <= pegs_d;
      held_q   <= held_d;
      bag_q    <= bag_d;
      steps_q  <= steps_d;
      solved_q <= solved_d;
      fault_q  <= fault_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ptr_d        = ptr_q;
    depth_d      = depth_q;
    pegs_d       = pegs_q;
    held_d       = held_q;
    bag_d        = bag_q;
    steps_d      = steps_q;
    solved_d     = solved_q;
    fault_d      = fault_q;
    exec_counted = 1'b0;
    any_full     = 1'b0;
    depth_n      = depth_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_EXEC;
          pc_d     = '0;
          ptr_d    = '0;
          depth_d  = '0;
          pegs_d   = PEGS_INIT;
          held_d   = '0;
          bag_d    = '0;
          steps_d  = '0;
          solved_d = 1'b0;
          fault_d  = FLT_NONE;
        end
      end

      ST_EXEC: begin
        if (!pc_in_range) begin
          state_d = ST_DONE;
          fault_d = FLT_NONE;
        end else begin
          exec_counted = 1'b1;
          pc_d         = pc_q + PC_ONE;
          case (tok)
            TOK_LEFT:  ptr_d = (ptr_q == '0) ? PTR_LAST : ptr_q - PTR_ONE;
            TOK_RIGHT: ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_ONE;
            TOK_INTERACT: begin
              // Taking from an empty peg leaves top_bit zero, so it degenerates to a no-op.
              if (held_q == '0) begin
                held_d = top_bit;
                pegs_d[int'(ptr_q)*N_DISKS +: N_DISKS] = cur_peg & ~top_bit;
              end else if (held_q > cur_peg) begin
                held_d = '0;
                pegs_d[int'(ptr_q)*N_DISKS +: N_DISKS] = cur_peg | held_q;
              end
            end
            TOK_SWAP: begin
              held_d = bag_q;
              bag_d  = held_q;
            end
            TOK_LOOP_BEGIN: begin
              if (held_q == '0) begin
                state_d = ST_SEEK_FWD;
                depth_d = DEPTH_ONE;
              end
            end
            TOK_LOOP_END: begin
              if (held_q != '0) begin
                state_d = ST_SEEK_BACK;
                depth_d = DEPTH_ONE;
                pc_d    = pc_q - PC_ONE;
              end
            end
            TOK_HALT: begin
              exec_counted = 1'b0;
              state_d      = ST_DONE;
              fault_d      = FLT_NONE;
            end
            default: begin
              exec_counted = 1'b0;
              state_d      = ST_DONE;
              fault_d      = FLT_ILLEGAL;
            end
          endcase

          if (exec_counted) begin
            steps_d = steps_q + STEP_ONE;
            for (int p = 1; p < N_PEGS; p++) begin
              if (&pegs_d[p*N_DISKS +: N_DISKS]) begin
                any_full = 1'b1;
              end
            end
            if (any_full) begin
              state_d  = ST_DONE;
              solved_d = 1'b1;
            end else if (steps_d == MAX_P) begin
              state_d = ST_DONE;
              fault_d = FLT_TIMEOUT;
            end
          end
        end
      end

      ST_SEEK_FWD, ST_SEEK_BACK: begin
        // Backward scan from address 0 wraps pc to all-ones, which lands out of range here.
        if (!pc_in_range) begin
          state_d = ST_DONE;
          fault_d = FLT_UNMATCHED;
        end else begin
          if (tok == TOK_LOOP_BEGIN) begin
            depth_n = (state_q == ST_SEEK_FWD) ? depth_q + DEPTH_ONE : depth_q - DEPTH_ONE;
          end else if (tok == TOK_LOOP_END) begin
            depth_n = (state_q == ST_SEEK_FWD) ? depth_q - DEPTH_ONE : depth_q + DEPTH_ONE;
          end
          depth_d = depth_n;
          if (depth_n == '0) begin
            pc_d    = pc_q + PC_ONE;
            state_d = ST_EXEC;
          end else begin
            pc_d = (state_q == ST_SEEK_FWD) ? pc_q + PC_ONE : pc_q - PC_ONE;
          end
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q == ST_EXEC) || (state_q == ST_SEEK_FWD) || (state_q == ST_SEEK_BACK);
    done       = (state_q == ST_DONE);
    solved     = solved_q;
    fault      = fault_q;
    step_count = steps_q;
    peg_state  = pegs_q;
    held       = held_q;
    bag        = bag_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_hanoi_core.sv
`default_nettype none
// ============================================================================
// tb_hanoi_core : directed + random programs on a 3-disk and a 1-disk core
// Rev 1.0
// ============================================================================
module tb_hanoi_core;

  localparam int DEPTH = 16;
  localparam int NP    = 3;
  localparam int ND0   = 3;
  localparam int MS0   = 40;
  localparam int ND1   = 1;
  localparam int MS1   = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       prog_we = 1'b0;
  logic [3:0] prog_addr = '0;
  logic [2:0] prog_data = '0;
  logic       start = 1'b0;

  logic        busy0, done0, solved0;
  logic [1:0]  fault0;
  logic [15:0] steps0;
  logic [8:0]  pegs0;
  logic [2:0]  held0, bag0;

  logic        busy1, done1, solved1;
  logic [1:0]  fault1;
  logic [15:0] steps1;
  logic [2:0]  pegs1;
  logic [0:0]  held1, bag1;

  int total = 0;
  int bad   = 0;
  logic [2:0] prog_m [DEPTH];

  hanoi_core #(.N_DISKS(ND0), .N_PEGS(NP), .PROG_DEPTH(DEPTH), .STEP_W(16), .MAX_STEPS(MS0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .start(start), .busy(busy0), .done(done0), .solved(solved0), .fault(fault0),
    .step_count(steps0), .peg_state(pegs0), .held(held0), .bag(bag0)
  );

  hanoi_core #(.N_DISKS(ND1), .N_PEGS(NP), .PROG_DEPTH(DEPTH), .STEP_W(16), .MAX_STEPS(MS1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .start(start), .busy(busy1), .done(done1), .solved(solved1), .fault(fault1),
    .step_count(steps1), .peg_state(pegs1), .held(held1), .bag(bag1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference interpreter: straight from the language rules, seeks resolved in zero time.
  task automatic model_run(input int nd, input int maxs, output int o_solved, output int o_fault,
                           output int o_steps, output logic [31:0] o_pegs, output int o_held,
                           output int o_bag);
    int  pegs [NP];
    int  full, held, bag, pc, ptr, steps, tok, depth, top;
    bit  seek_fail;
    full = (1 << nd) - 1;
    pegs[0] = full;
    for (int q = 1; q < NP; q++) pegs[q] = 0;
    held = 0; bag = 0; pc = 0; ptr = 0; steps = 0;
    o_solved = 0; o_fault = 0;
    for (int g = 0; g < 100000; g++) begin
      if (pc >= DEPTH) break;
      tok = int'(prog_m[pc]);
      if (tok == 6) break;
      if (tok == 7) begin o_fault = 3; break; end
      steps++;
      seek_fail = 0;
      case (tok)
        0: begin ptr = (ptr + NP - 1) % NP; pc++; end
        1: begin ptr = (ptr + 1) % NP; pc++; end
        2: begin
          if (held == 0) begin
            top = 0;
            for (int b = 0; b < nd; b++) if (((pegs[ptr] >> b) & 1) == 1) top = 1 << b;
            held = top;
            pegs[ptr] = pegs[ptr] & ~top;
          end else if (held > pegs[ptr]) begin
            pegs[ptr] = pegs[ptr] | held;
            held = 0;
          end
          pc++;
        end
        5: begin top = held; held = bag; bag = top; pc++; end
        3: begin
          if (held != 0) pc++;
          else begin
            depth = 1; pc++;
            while (depth != 0 && pc < DEPTH) begin
              if (prog_m[pc] == 3'd3) depth++;
              else if (prog_m[pc] == 3'd4) depth--;
              pc++;
            end
            if (depth != 0) seek_fail = 1;
          end
        end
        default: begin
          if (held == 0) pc++;
          else begin
            depth = 1; pc--;
            while (depth != 0 && pc >= 0) begin
              if (prog_m[pc] == 3'd4) depth++;
              else if (prog_m[pc] == 3'd3) depth--;
              if (depth != 0) pc--;
            end
            if (depth != 0) seek_fail = 1;
            else pc++;
          end
        end
      endcase
      for (int q = 1; q < NP; q++) if (pegs[q] == full) o_solved = 1;
      if (o_solved != 0) break;
      if (steps == maxs) begin o_fault = 2; break; end
      if (seek_fail) begin o_fault = 1; break; end
    end
    o_steps = steps;
    o_held  = held;
    o_bag   = bag;
    o_pegs  = '0;
    for (int q = 0; q < NP; q++) o_pegs = o_pegs | (32'(pegs[q]) << (q * nd));
  endtask

  task automatic load_prog();
    for (int a = 0; a < DEPTH; a++) begin
      @(negedge clk);
      prog_we = 1'b1; prog_addr = 4'(a); prog_data = prog_m[a];
    end
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  // Start pulse; optionally a program write in the very same idle cycle.
  task automatic kick(input bit wr, input int wa);
    @(negedge clk);
    start = 1'b1;
    if (wr) begin
      prog_we = 1'b1; prog_addr = 4'(wa); prog_data = prog_m[wa];
    end
    @(negedge clk);
    start = 1'b0; prog_we = 1'b0;
  endtask

  task automatic wait_and_check(input string name, input bit junk);
    int cyc, cnt0, cnt1;
    int m_sol, m_flt, m_stp, m_hld, m_bag;
    logic [31:0] m_pg;
    cyc = 0; cnt0 = 0; cnt1 = 0;
    while (!(cnt0 > 0 && cnt1 > 0) && cyc < 2000) begin
      if (done0) cnt0++;
      if (done1) cnt1++;
      // Writes/starts are only driven while both cores are busy, so they must be ignored.
      if (junk && busy0 && busy1) begin
        prog_we = 1'b1; prog_addr = 4'($urandom_range(0, DEPTH-1));
        prog_data = 3'($urandom_range(0, 7)); start = 1'($urandom_range(0, 1));
      end else begin
        prog_we = 1'b0; start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    prog_we = 1'b0; start = 1'b0;
    chk({name, ".finished"}, 32'(cnt0 > 0 && cnt1 > 0), 1);
    repeat (2) begin
      if (done0) cnt0++;
      if (done1) cnt1++;
      @(negedge clk);
    end
    chk({name, ".done_cnt0"}, cnt0, 1);
    chk({name, ".done_cnt1"}, cnt1, 1);
    chk({name, ".busy0"}, busy0, 0);
    model_run(ND0, MS0, m_sol, m_flt, m_stp, m_pg, m_hld, m_bag);
    chk({name, ".solved0"}, solved0, m_sol);
    chk({name, ".fault0"},  fault0,  m_flt);
    chk({name, ".steps0"},  steps0,  m_stp);
    chk({name, ".pegs0"},   pegs0,   m_pg);
    chk({name, ".held0"},   held0,   m_hld);
    chk({name, ".bag0"},    bag0,    m_bag);
    model_run(ND1, MS1, m_sol, m_flt, m_stp, m_pg, m_hld, m_bag);
    chk({name, ".solved1"}, solved1, m_sol);
    chk({name, ".fault1"},  fault1,  m_flt);
    chk({name, ".steps1"},  steps1,  m_stp);
    chk({name, ".pegs1"},   pegs1,   m_pg);
    chk({name, ".held1"},   held1,   m_hld);
    chk({name, ".bag1"},    bag1,    m_bag);
  endtask

  task automatic fill(input logic [2:0] t);
    for (int a = 0; a < DEPTH; a++) prog_m[a] = t;
  endtask

  initial begin
    int r;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.busy0", busy0, 0);
    chk("rst.done0", done0, 0);
    chk("rst.solved0", solved0, 0);
    chk("rst.fault0", fault0, 0);
    chk("rst.steps0", steps0, 0);
    chk("rst.pegs0", pegs0, 9'h007);
    chk("rst.held0", held0, 0);
    chk("rst.bag0", bag0, 0);
    chk("rst.pegs1", pegs1, 3'b001);
    rst_n = 1'b1;

    // Take, move right, place; HALT at addr 3 is written together with start.
    fill(3'd6);
    prog_m[0] = 3'd2; prog_m[1] = 3'd1; prog_m[2] = 3'd2; prog_m[3] = 3'd7;
    load_prog();
    prog_m[3] = 3'd6;
    kick(1'b1, 3);
    wait_and_check("t1", 1'b0);
    chk("t1.steps0_k", steps0, 3);
    chk("t1.pegs0_k", pegs0, 9'h023);
    chk("t1.solved1_k", solved1, 1);
    chk("t1.pegs1_k", pegs1, 3'b010);

    // Larger disk refused on top of the smallest.
    fill(3'd6);
    prog_m[0] = 3'd2; prog_m[1] = 3'd1; prog_m[2] = 3'd2; prog_m[3] = 3'd0;
    prog_m[4] = 3'd2; prog_m[5] = 3'd1; prog_m[6] = 3'd2;
    load_prog();
    kick(1'b0, 0);
    wait_and_check("t2", 1'b1);
    chk("t2.held0_k", held0, 3'b010);
    chk("t2.pegs0_k", pegs0, 9'h021);

    // Endless LOOP_END -> timeout.
    fill(3'd6);
    prog_m[0] = 3'd2; prog_m[1] = 3'd3; prog_m[2] = 3'd4;
    load_prog();
    kick(1'b0, 0);
    wait_and_check("t3", 1'b1);
    chk("t3.fault1_k", fault1, 2);
    chk("t3.steps1_k", steps1, 16);
    chk("t3.steps0_k", steps0, MS0);

    // LOOP_END with nothing before it to match.
    fill(3'd6);
    prog_m[0] = 3'd2; prog_m[1] = 3'd4;
    load_prog();
    kick(1'b0, 0);
    wait_and_check("t4", 1'b0);
    chk("t4.fault0_k", fault0, 1);

    // Illegal token.
    fill(3'd6);
    prog_m[0] = 3'd1; prog_m[1] = 3'd7;
    load_prog();
    kick(1'b0, 0);
    wait_and_check("t5", 1'b0);
    chk("t5.fault0_k", fault0, 3);

    // Reset during a forward seek, then rerun the untouched program.
    fill(3'd1);
    prog_m[0] = 3'd3;
    load_prog();
    kick(1'b0, 0);
    repeat (4) @(negedge clk);
    chk("rs.busy_mid", busy0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rs.busy0", busy0, 0);
    chk("rs.pegs0", pegs0, 9'h007);
    chk("rs.pegs1", pegs1, 3'b001);
    chk("rs.steps0", steps0, 0);
    @(negedge clk);
    chk("rs.done0", done0, 0);
    rst_n = 1'b1;
    kick(1'b0, 0);
    wait_and_check("rs.rerun", 1'b0);

    for (int it = 0; it < 30; it++) begin
      if (it == 0 || $urandom_range(0, 1) == 1) begin
        for (int a = 0; a < DEPTH; a++) begin
          r = int'($urandom_range(0, 99));
          if (r < 85) prog_m[a] = 3'($urandom_range(0, 5));
          else if (r < 97) prog_m[a] = 3'd6;
          else prog_m[a] = 3'd7;
        end
        load_prog();
      end
      kick(1'b0, 0);
      wait_and_check($sformatf("rnd%0d", it), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got=running expected=finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
